seq_mul: RTL

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_if.sv | 17 +
 rtl/seq_mul.sv | 96 +++++++++
 2 files changed

// File: rtl/seq_mul_if.sv
// Request/result bundle for the sequential multiplier; the state field exposes the FSM for observation.
interface seq_mul_if #(
    parameter int W = 8
);
    logic           start;
    logic           sgn;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W:0]   O;
    logic           fin;
    logic           busy;
    logic [1:0]     state;

    // start/sgn/A/B are sampled only on the edge that leaves IDLE; fin pulses one cycle with O valid.
    modport master (output start, sgn, A, B, input O, fin, busy, state);
    modport slave  (input start, sgn, A, B, output O, fin, busy, state);
endinterface

// File: rtl/seq_mul.sv
// Shift-add multiplier, one multiplier bit per cycle, signed mode via magnitudes plus final negate.
module seq_mul #(
    parameter int W = 8
) (
    input  logic   ck,
    input  logic   rst_n,
    seq_mul_if.slave bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*W:0] mcand_q, mcand_d;
    logic [W-1:0] mplr_q, mplr_d;
    logic         neg_q, neg_d;
    logic [2*W:0] acc_q, acc_d;
    logic [2*W:0] o_q, o_d;
    logic         fin_q, fin_d;

    // Magnitude of a W-bit operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned in W bits.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        return (s && x[W-1]) ? (~x + W'(1)) : x;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        o_d     = o_q;
        fin_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    mcand_d = {{(W+1){1'b0}}, mag(bus.A, bus.sgn)};
                    mplr_d  = mag(bus.B, bus.sgn);
                    neg_d   = bus.sgn & (bus.A[W-1] ^ bus.B[W-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    o_d     = neg_q ? -acc_d : acc_d;
                    fin_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            o_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.O     = o_q;
    assign bus.fin   = fin_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.state = state_q;
endmodule
